// File: rtl/weight_loader.sv
// Weight tile sequencer: streams one MATRIX_WIDTH x MATRIX_WIDTH byte tile from the
// weight buffer into the MMU preload port, zero-filling unused rows, then fires activation.
module weight_loader #(
    parameter int MATRIX_WIDTH   = 14,
    parameter int BUF_ADDR_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [BUF_ADDR_WIDTH-1:0]   base_addr,
    input  logic [7:0]                  row_count,
    input  logic                        signed_in,
    input  logic                        auto_activate,
    input  logic                        activate_req,
    output logic                        busy,
    output logic                        done,
    output logic                        buf_en,
    output logic [BUF_ADDR_WIDTH-1:0]   buf_addr,
    input  logic [8*MATRIX_WIDTH-1:0]   buf_rdata,
    output logic [8*MATRIX_WIDTH-1:0]   weight_data,
    output logic                        weight_signed,
    output logic                        load_weight,
    output logic [7:0]                  weight_addr,
    output logic                        activate_weight
);

    localparam int         DW  = 8 * MATRIX_WIDTH;
    localparam logic [7:0] MW8 = 8'(MATRIX_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        WAIT_ACT,
        ACTIVATE
    } state_t;

    state_t                     state_reg, state_next;
    logic [7:0]                 row_reg, row_next;
    logic                       drain_reg, drain_next;
    logic                       accept;

    logic [BUF_ADDR_WIDTH-1:0]  base_reg;
    logic [7:0]                 rc_reg;
    logic                       auto_reg;

    logic [BUF_ADDR_WIDTH-1:0]  cmd_base;
    logic [7:0]                 cmd_rc;
    logic [7:0]                 clamped_rc;
    logic                       issue_valid;
    logic                       issue_zero;
    logic                       issue_en;

    // Two-stage pipeline aligning row metadata with the one-cycle buffer read latency.
    logic                       s1_valid_reg, s1_zero_reg;
    logic [7:0]                 s1_row_reg;
    logic                       s2_valid_reg, s2_zero_reg;
    logic [7:0]                 s2_row_reg;

    logic                       busy_reg;
    logic                       done_reg;
    logic                       activate_reg;
    logic                       buf_en_reg;
    logic [BUF_ADDR_WIDTH-1:0]  buf_addr_reg;
    logic [DW-1:0]              weight_data_reg;
    logic                       weight_signed_reg;
    logic                       load_weight_reg;
    logic [7:0]                 weight_addr_reg;

    logic                       row_keep;
    logic [DW-1:0]              row_masked;

    assign clamped_rc = (row_count > MW8) ? MW8 : row_count;

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        drain_next = drain_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                    row_next   = 8'd0;
                end
            end
            LOAD: begin
                if (row_reg == MW8 - 8'd1) begin
                    state_next = DRAIN;
                    row_next   = 8'd0;
                    drain_next = 1'b0;
                end else begin
                    row_next = row_reg + 8'd1;
                end
            end
            DRAIN: begin
                if (drain_reg) begin
                    state_next = auto_reg ? ACTIVATE : WAIT_ACT;
                    drain_next = 1'b0;
                end else begin
                    drain_next = 1'b1;
                end
            end
            WAIT_ACT: begin
                if (activate_req) begin
                    state_next = ACTIVATE;
                end
            end
            ACTIVATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // On the accepting edge the latched command is not yet visible, so use the inputs directly.
    always_comb begin
        cmd_base    = accept ? base_addr : base_reg;
        cmd_rc      = accept ? clamped_rc : rc_reg;
        issue_valid = (state_next == LOAD);
        issue_zero  = (row_next >= cmd_rc);
        issue_en    = issue_valid && !issue_zero;
    end

    assign row_keep = s2_valid_reg && !s2_zero_reg;

    generate
        for (genvar gi = 0; gi < MATRIX_WIDTH; gi++) begin : g_byte_mask
            assign row_masked[gi*8 +: 8] = row_keep ? buf_rdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            row_reg           <= 8'd0;
            drain_reg         <= 1'b0;
            base_reg          <= '0;
            rc_reg            <= 8'd0;
            auto_reg          <= 1'b0;
            s1_valid_reg      <= 1'b0;
            s1_zero_reg       <= 1'b0;
            s1_row_reg        <= 8'd0;
            s2_valid_reg      <= 1'b0;
            s2_zero_reg       <= 1'b0;
            s2_row_reg        <= 8'd0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            activate_reg      <= 1'b0;
            buf_en_reg        <= 1'b0;
            buf_addr_reg      <= '0;
            weight_data_reg   <= '0;
            weight_signed_reg <= 1'b0;
            load_weight_reg   <= 1'b0;
            weight_addr_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            drain_reg <= drain_next;

            if (accept) begin
                base_reg          <= base_addr;
                rc_reg            <= clamped_rc;
                auto_reg          <= auto_activate;
                weight_signed_reg <= signed_in;
            end

            busy_reg     <= (state_next != IDLE);
            done_reg     <= (state_next == ACTIVATE);
            activate_reg <= (state_next == ACTIVATE);

            buf_en_reg   <= issue_en;
            buf_addr_reg <= issue_en ? (cmd_base + BUF_ADDR_WIDTH'(row_next)) : '0;

            s1_valid_reg <= issue_valid;
            s1_zero_reg  <= issue_zero;
            s1_row_reg   <= issue_valid ? row_next : 8'd0;
            s2_valid_reg <= s1_valid_reg;
            s2_zero_reg  <= s1_zero_reg;
            s2_row_reg   <= s1_row_reg;

            load_weight_reg <= s2_valid_reg;
            weight_addr_reg <= s2_valid_reg ? s2_row_reg : 8'd0;
            weight_data_reg <= row_masked;
        end
    end

    assign busy            = busy_reg;
    assign done            = done_reg;
    assign activate_weight = activate_reg;
    assign buf_en          = buf_en_reg;
    assign buf_addr        = buf_addr_reg;
    assign weight_data     = weight_data_reg;
    assign weight_signed   = weight_signed_reg;
    assign load_weight     = load_weight_reg;
    assign weight_addr     = weight_addr_reg;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader (MATRIX_WIDTH=4): per-cycle comparison against a timeline model
// of each command, plus directed literal checks and a randomized input phase.
module tb_weight_loader;

    localparam int MW = 4;
    localparam int AW = 16;
    localparam int DW = 8 * MW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    row_count = 8'd0;
    logic          signed_in = 1'b0;
    logic          auto_activate = 1'b0;
    logic          activate_req = 1'b0;
    logic          busy, done, buf_en, weight_signed, load_weight, activate_weight;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_rdata = '0;
    logic [DW-1:0] weight_data;
    logic [7:0]    weight_addr;

    weight_loader #(.MATRIX_WIDTH(MW), .BUF_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
        .signed_in(signed_in), .auto_activate(auto_activate), .activate_req(activate_req),
        .busy(busy), .done(done), .buf_en(buf_en), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
        .weight_data(weight_data), .weight_signed(weight_signed), .load_weight(load_weight),
        .weight_addr(weight_addr), .activate_weight(activate_weight)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          chk_on = 1'b0;
    logic [31:0] salt = 32'h0;
    int          t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer contents: with salt 0, row at address 0x10+k has every byte equal to k+1.
    function automatic logic [DW-1:0] mem_row(input logic [AW-1:0] a);
        logic [7:0] b;
        b = 8'(a - 16'h000F);
        return {MW{b}} ^ salt;
    endfunction

    always @(posedge clk) buf_rdata <= buf_en ? mem_row(buf_addr) : DW'($urandom());

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    // Model: one active command described by its accept cycle, clamped row count and activation cycle.
    bit          m_active = 1'b0;
    int          m_c0 = 0;
    int          m_rc = 0;
    int          m_act = -1;
    bit          m_auto = 1'b0;
    logic        m_signed = 1'b0;
    logic [AW-1:0] m_base = '0;

    int            k;
    logic          e_busy, e_done, e_en, e_load;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_waddr;
    logic [DW-1:0] e_data;

    always @(negedge clk) begin
        if (chk_on) begin
            k       = cyc - m_c0;
            e_busy  = m_active;
            e_en    = m_active && k >= 1 && k <= MW && (k - 1) < m_rc;
            e_addr  = e_en ? AW'(m_base + AW'(k - 1)) : '0;
            e_load  = m_active && k >= 3 && k <= MW + 2;
            e_waddr = e_load ? 8'(k - 3) : 8'd0;
            e_data  = (e_load && (k - 3) < m_rc) ? mem_row(AW'(m_base + AW'(k - 3))) : '0;
            e_done  = m_active && (cyc == m_act);
            check("ctrl", 64'({busy, done, activate_weight, load_weight, buf_en}),
                  64'({e_busy, e_done, e_done, e_load, e_en}));
            check("buf_addr", 64'(buf_addr), 64'(e_addr));
            check("weight_addr", 64'(weight_addr), 64'(e_waddr));
            check("weight_data", 64'(weight_data), 64'(e_data));
            check("weight_signed", 64'(weight_signed), 64'(m_signed));

            if (rst) begin
                m_active = 1'b0;
                m_signed = 1'b0;
            end else if (m_active && cyc == m_act) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_c0     = cyc;
                    m_base   = base_addr;
                    m_rc     = (int'(row_count) > MW) ? MW : int'(row_count);
                    m_auto   = auto_activate;
                    m_signed = signed_in;
                    m_act    = auto_activate ? cyc + MW + 3 : -1;
                end
            end else if (!m_auto && m_act < 0 && (cyc - m_c0) >= MW + 3 && activate_req) begin
                m_act = cyc + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) tick();
    endtask

    task automatic cmd(input logic [AW-1:0] b, input logic [7:0] rc, input logic s, input logic a);
        base_addr     = b;
        row_count     = rc;
        signed_in     = s;
        auto_activate = a;
        start         = 1'b1;
        t0            = cyc;
        tick();
        start = 1'b0;
    endtask

    int t1;

    initial begin
        tick();
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("reset_busy", 64'(busy), 64'd0);

        // Full tile, auto activation
        cmd(16'h0010, 8'd4, 1'b0, 1'b1);
        check("t1_en_c1", 64'({buf_en, busy, buf_addr}), 64'({2'b11, 16'h0010}));
        wait_cycle(t0 + 3);
        check("t1_load_c3", 64'({load_weight, weight_addr, weight_data}), 64'({1'b1, 8'd0, 32'h01010101}));
        wait_cycle(t0 + 6);
        check("t1_load_c6", 64'({load_weight, weight_addr, weight_data}), 64'({1'b1, 8'd3, 32'h04040404}));
        wait_cycle(t0 + 7);
        check("t1_act_c7", 64'({activate_weight, done, busy}), 64'(3'b111));
        tick();
        check("t1_idle_c8", 64'({busy, activate_weight}), 64'd0);
        tick();

        // Partial tile, then empty tile
        cmd(16'h0010, 8'd2, 1'b0, 1'b1);
        wait_cycle(t0 + 3);
        check("t2_noen_c3", 64'(buf_en), 64'd0);
        wait_cycle(t0 + 5);
        check("t2_zero_c5", 64'({load_weight, weight_addr, weight_data}), 64'({1'b1, 8'd2, 32'h0}));
        wait_cycle(t0 + 9);
        cmd(16'h0010, 8'd0, 1'b0, 1'b1);
        check("t2_rc0_noen", 64'(buf_en), 64'd0);
        wait_cycle(t0 + 4);
        check("t2_rc0_zero", 64'({load_weight, weight_data}), 64'({1'b1, 32'h0}));
        wait_cycle(t0 + 9);

        // Manual activation
        cmd(16'h0010, 8'd4, 1'b0, 1'b0);
        wait_cycle(t0 + 3);
        activate_req = 1'b1;
        tick();
        activate_req = 1'b0;
        wait_cycle(t0 + 12);
        check("t3_wait_c12", 64'({busy, activate_weight}), 64'(2'b10));
        activate_req = 1'b1;
        tick();
        activate_req = 1'b0;
        check("t3_act_c13", 64'({activate_weight, done, busy}), 64'(3'b111));
        tick();
        check("t3_idle_c14", 64'(busy), 64'd0);
        tick();

        // Address wrap
        cmd(16'hFFFE, 8'd4, 1'b0, 1'b1);
        wait_cycle(t0 + 3);
        check("t4_wrap_c3", 64'(buf_addr), 64'h0000);
        tick();
        check("t4_wrap_c4", 64'(buf_addr), 64'h0001);
        wait_cycle(t0 + 9);

        // Reset mid-load, then ignored start while busy, then fresh command
        cmd(16'h0010, 8'd4, 1'b1, 1'b1);
        wait_cycle(t0 + 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_c5", 64'({busy, load_weight, buf_en, weight_signed}), 64'd0);
        wait_cycle(t0 + 7);
        check("t5_nodone", 64'({done, activate_weight}), 64'd0);
        tick();
        cmd(16'h0010, 8'd4, 1'b0, 1'b1);
        t1 = t0;
        wait_cycle(t1 + 3);
        base_addr = 16'h0200;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_cycle(t1 + 7);
        check("t5_act_c7", 64'(activate_weight), 64'd1);
        wait_cycle(t1 + 9);
        check("t5_ignored", 64'({busy, buf_en}), 64'd0);
        cmd(16'h0010, 8'd4, 1'b0, 1'b1);
        wait_cycle(t0 + 7);
        check("t5_fresh_c7", 64'({activate_weight, done}), 64'(2'b11));
        wait_cycle(t0 + 9);

        // Signedness latch and row clamp
        cmd(16'h0040, 8'd20, 1'b1, 1'b1);
        check("t6_sgn_c1", 64'(weight_signed), 64'd1);
        for (int i = 0; i < 5; i++) begin
            signed_in = ~signed_in;
            row_count = 8'($urandom);
            tick();
        end
        check("t6_sgn_c6", 64'(weight_signed), 64'd1);
        wait_cycle(t0 + 10);
        check("t6_sgn_idle", 64'(weight_signed), 64'd1);
        cmd(16'h0040, 8'd4, 1'b0, 1'b1);
        check("t6_sgn_new", 64'(weight_signed), 64'd0);
        wait_cycle(t0 + 9);

        // Randomized inputs every cycle
        salt = $urandom();
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            start         = ($urandom_range(0, 5) == 0);
            activate_req  = ($urandom_range(0, 3) == 0);
            base_addr     = AW'($urandom());
            row_count     = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 6));
            signed_in     = 1'($urandom());
            auto_activate = 1'($urandom());
            tick();
        end
        rst          = 1'b0;
        start        = 1'b0;
        activate_req = 1'b1;
        repeat (30) tick();
        activate_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
